// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian 16-bit words from a
// byte stream and writes them from address 0 until the FFFF terminator is stored.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_init,
    output logic              busy,
    output logic              done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_hi;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [15:0]         r_wr_data;
    logic [ADDR_W:0]     r_word_count;
    logic                r_done;
    logic                r_err;
    logic                r_cpu_init;

    logic                w_rx_ready;
    logic                w_xfer;
    logic                w_start_ok;
    logic                w_last_addr;
    logic                w_term;

    // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are
    // both 1; rx_ready depends only on state, never on rx_valid.
    assign w_rx_ready  = (r_state == S_HI) || (r_state == S_LO);
    assign w_xfer      = rx_valid && w_rx_ready;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
    assign w_last_addr = (r_addr == {ADDR_W{1'b1}});
    assign w_term      = (r_wr_data == 16'hFFFF);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_HI;
            S_HI:    if (w_xfer) w_next = S_LO;
            S_LO:    if (w_xfer) w_next = S_WRITE;
            S_WRITE: begin
                // Terminator wins even when it lands in the last address.
                if (w_term)           w_next = S_DONE;
                else if (w_last_addr) w_next = S_ERR;
                else                  w_next = S_HI;
            end
            S_DONE:  if (w_start_ok) w_next = S_HI;
            S_ERR:   if (w_start_ok) w_next = S_HI;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_hi         <= 8'h00;
            r_addr       <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= 16'h0000;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_init   <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_HI && w_xfer) begin
                r_hi <= rx_data;
            end
            // Output address/data are loaded together so they only change on
            // entry to WRITE and hold otherwise.
            if (r_state == S_LO && w_xfer) begin
                r_wr_data <= {r_hi, rx_data};
                r_wr_addr <= r_addr;
            end
            if (w_start_ok) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end
            if (r_state == S_WRITE) begin
                r_word_count <= r_word_count + 1'b1;
                if (w_next == S_HI) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
            r_done     <= (w_next == S_DONE);
            r_err      <= (w_next == S_ERR);
            r_cpu_init <= (w_next != S_DONE);
        end
    end

    assign rx_ready     = w_rx_ready;
    assign wr_en        = (r_state == S_WRITE);
    assign busy         = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_WRITE);
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign word_count   = r_word_count;
    assign done         = r_done;
    assign overflow_err = r_err;
    assign cpu_init     = r_cpu_init;
    assign dbg_state    = r_state;

endmodule
